// File: rtl/bcd_score_counter_if.sv
// Score counter bus: clear/add/sub inputs plus score, high-score, flags and HEX.
// master drives clear/add/sub and observes outputs; slave is the counter.
interface bcd_score_counter_if #(
  parameter int DIGITS = 2,
  parameter int INC_W  = 2
);
  logic                  clear;
  logic [INC_W-1:0]      add;
  logic [INC_W-1:0]      sub;
  logic [4*DIGITS-1:0]   score_bcd;
  logic [4*DIGITS-1:0]   high_bcd;
  logic                  new_high;
  logic                  overflow;
  logic                  underflow;
  logic                  maxed;
  logic [7*DIGITS-1:0]   hex;

  modport master (
    output clear, add, sub,
    input  score_bcd, high_bcd, new_high,
    input  overflow, underflow, maxed, hex
  );

  modport slave (
    input  clear, add, sub,
    output score_bcd, high_bcd, new_high,
    output overflow, underflow, maxed, hex
  );
endinterface

// File: rtl/bcd_score_counter.sv
// N-digit BCD score counter: add/sub per cycle, saturate or wrap, high score, HEX.
// Ports: clk, reset (async high), bus (slave: clear/add/sub in; score/high/flags/hex out).
module bcd_score_counter #(
  parameter int DIGITS   = 2,
  parameter int INC_W    = 2,
  parameter int SATURATE = 1,
  parameter int BLANK_LZ = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_score_counter_if.slave   bus
);

  localparam int SW = 4 * DIGITS;
  localparam int MW = INC_W + 1;
  localparam logic [SW-1:0] MAX_BCD = {DIGITS{4'h9}};

  typedef enum logic {RUN, MAXED} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   score_q, score_d;
  logic [SW-1:0]   high_q, high_d;
  logic            nh_q, nh_d;
  logic            ov_q, ov_d;
  logic            un_q, un_d;

  logic [INC_W-1:0] add_eff;
  logic [MW-1:0]    mag;
  logic             neg;
  logic [4:0]       m5;
  logic [3:0]       ones;
  logic             tens;
  logic [SW-1:0]    sum_v;
  logic             cy;
  logic             cy_out;
  logic [4:0]       t;
  logic [3:0]       op;

  // Net increment as sign + magnitude, magnitude split into two BCD digits.
  always_comb begin
    add_eff = (state_q == MAXED) ? '0 : bus.add;
    neg     = 1'b0;
    mag     = MW'(add_eff) - MW'(bus.sub);
    if (add_eff < bus.sub) begin
      neg = 1'b1;
      mag = MW'(bus.sub) - MW'(add_eff);
    end
    m5   = 5'(mag);
    tens = (m5 >= 5'd10);
    ones = tens ? 4'(m5 - 5'd10) : 4'(m5);
  end

  // Digit-wise ripple; cy is carry when adding, borrow when subtracting.
  always_comb begin
    sum_v = '0;
    cy    = 1'b0;
    t     = '0;
    op    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      op = (k == 0) ? ones : ((k == 1) ? {3'b000, tens} : 4'd0);
      if (!neg) begin
        t  = {1'b0, score_q[4*k+:4]} + {1'b0, op} + {4'b0, cy};
        cy = (t > 5'd9);
        if (cy) t = t - 5'd10;
      end else begin
        t  = {1'b0, score_q[4*k+:4]} + 5'd10 - {1'b0, op} - {4'b0, cy};
        cy = (t < 5'd10);
        if (!cy) t = t - 5'd10;
      end
      sum_v[4*k+:4] = t[3:0];
    end
    // A single-digit counter has no slot for the tens digit of the step.
    cy_out = cy | ((DIGITS == 1) & tens);
  end

  always_comb begin
    score_d = sum_v;
    ov_d    = 1'b0;
    un_d    = 1'b0;
    if (bus.clear) begin
      score_d = '0;
    end else if (cy_out && neg) begin
      score_d = '0;
      un_d    = 1'b1;
    end else if (cy_out) begin
      ov_d = 1'b1;
      if (SATURATE != 0) score_d = MAX_BCD;
    end
    // Valid BCD orders the same as plain unsigned compare.
    nh_d   = (score_q > high_q);
    high_d = nh_d ? score_q : high_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:
        if (SATURATE != 0 && score_d == MAX_BCD)
          state_d = MAXED;
      MAXED:
        if (bus.sub != '0 || bus.clear)
          state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      score_q <= '0;
      high_q  <= '0;
      nh_q    <= 1'b0;
      ov_q    <= 1'b0;
      un_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      high_q  <= high_d;
      nh_q    <= nh_d;
      ov_q    <= ov_d;
      un_q    <= un_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    unique case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7f;
    endcase
  endfunction

  logic [7*DIGITS-1:0] hex_v;
  logic                nz;
  logic [6:0]          seg;

  // Walk from the top digit down; blank until a nonzero digit is seen.
  always_comb begin
    hex_v = '1;
    nz    = 1'b0;
    seg   = 7'h7f;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz  = nz | (score_q[4*k+:4] != 4'd0);
      seg = seg7(score_q[4*k+:4]);
      if (BLANK_LZ != 0 && k != 0 && !nz) seg = 7'h7f;
      hex_v[7*k+:7] = seg;
    end
  end

  assign bus.score_bcd = score_q;
  assign bus.high_bcd  = high_q;
  assign bus.new_high  = nh_q;
  assign bus.overflow  = ov_q;
  assign bus.underflow = un_q;
  assign bus.maxed     = (state_q == MAXED);
  assign bus.hex       = hex_v;

endmodule
